feedback_scheduler: RTL and testbench

FEEDBACK_SCHEDULER -- requirements
Module: feedback_scheduler

---
 rtl/feedback_scheduler.sv | 177 +++++++++++++++++
 tb/tb_feedback_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/feedback_scheduler.sv
// Sequences one training pass over clause memory: read each masked-in clause,
// hand it to the feedback datapath for one cycle, then write the result back.
module feedback_scheduler #(
    parameter  int CLAUSE_NUM   = 4,
    parameter  int LITERAL_NUM  = 8,
    parameter  int STATE_WIDTH  = 4,
    parameter  int WEIGHT_WIDTH = 8,
    localparam int AW = (CLAUSE_NUM > 1) ? $clog2(CLAUSE_NUM) : 1,
    localparam int SW = LITERAL_NUM * STATE_WIDTH,
    localparam int MW = WEIGHT_WIDTH + SW
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_is_positive_sample,
    input  logic [LITERAL_NUM-1:0]  i_literals,
    input  logic [CLAUSE_NUM-1:0]   i_conjunction_result,
    input  logic [CLAUSE_NUM-1:0]   i_clause_mask,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_mem_rd_en,
    output logic                    o_mem_wr_en,
    output logic [AW-1:0]           o_mem_addr,
    input  logic [MW-1:0]           i_mem_rd_data,
    output logic [MW-1:0]           o_mem_wr_data,
    output logic                    o_fb_en,
    output logic                    o_fb_is_positive,
    output logic                    o_fb_match,
    output logic [LITERAL_NUM-1:0]  o_fb_actions,
    output logic [LITERAL_NUM-1:0]  o_fb_literals,
    output logic [SW-1:0]           o_fb_state_in,
    output logic [WEIGHT_WIDTH-1:0] o_fb_weight_in,
    input  logic [SW-1:0]           i_fb_state_out,
    input  logic [WEIGHT_WIDTH-1:0] i_fb_weight_out
);

    // state | meaning
    // IDLE  | waiting for start; done pulses here for one cycle after a pass
    // SCAN  | current clause masked out; skip it or end the pass
    // READ  | clause memory read strobe for clause c
    // LOAD  | read data captured into the operand registers
    // APPLY | feedback datapath enabled for clause c
    // WRITE | datapath result written back to clause c
    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_READ, S_LOAD, S_APPLY, S_WRITE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(CLAUSE_NUM - 1);

    state_t                  r_state;
    logic [AW-1:0]           r_c;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_mem_rd_en;
    logic                    r_mem_wr_en;
    logic                    r_fb_en;
    logic                    r_pos;
    logic [LITERAL_NUM-1:0]  r_lits;
    logic [CLAUSE_NUM-1:0]   r_conj;
    logic [CLAUSE_NUM-1:0]   r_mask;
    logic [SW-1:0]           r_state_op;
    logic [WEIGHT_WIDTH-1:0] r_weight_op;
    logic [AW-1:0]           w_c_next;
    logic [LITERAL_NUM-1:0]  w_actions;

    assign w_c_next = r_c + AW'(1);

    // Transitions into the next clause look ahead at its mask bit so a
    // masked-in clause costs exactly READ/LOAD/APPLY/WRITE with no SCAN cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_c         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_fb_en     <= 1'b0;
            r_pos       <= 1'b0;
            r_lits      <= '0;
            r_conj      <= '0;
            r_mask      <= '0;
            r_state_op  <= '0;
            r_weight_op <= '0;
        end else begin
            r_done      <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_wr_en <= 1'b0;
            r_fb_en     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pos  <= i_is_positive_sample;
                        r_lits <= i_literals;
                        r_conj <= i_conjunction_result;
                        r_mask <= i_clause_mask;
                        r_c    <= '0;
                        r_busy <= 1'b1;
                        if (i_clause_mask[0]) begin
                            r_state     <= S_READ;
                            r_mem_rd_en <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_mask[r_c]) begin
                        r_state     <= S_READ;
                        r_mem_rd_en <= 1'b1;
                    end else if (r_c == LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_c <= w_c_next;
                        if (r_mask[w_c_next]) begin
                            r_state     <= S_READ;
                            r_mem_rd_en <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_READ: r_state <= S_LOAD;
                S_LOAD: begin
                    {r_weight_op, r_state_op} <= i_mem_rd_data;
                    r_fb_en                   <= 1'b1;
                    r_state                   <= S_APPLY;
                end
                S_APPLY: begin
                    r_mem_wr_en <= 1'b1;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    if (r_c == LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_c <= w_c_next;
                        if (r_mask[w_c_next]) begin
                            r_state     <= S_READ;
                            r_mem_rd_en <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_actions = '0;
        for (int i = 0; i < LITERAL_NUM; i++) begin
            w_actions[i] = r_state_op[i*STATE_WIDTH + STATE_WIDTH - 1];
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_mem_rd_en      = r_mem_rd_en;
    assign o_mem_wr_en      = r_mem_wr_en;
    assign o_mem_addr       = r_c;
    // Datapath results are only meaningful during the write cycle.
    assign o_mem_wr_data    = r_mem_wr_en ? {i_fb_weight_out, i_fb_state_out} : '0;
    assign o_fb_en          = r_fb_en;
    assign o_fb_is_positive = r_pos;
    assign o_fb_match       = r_conj[r_c];
    assign o_fb_actions     = w_actions;
    assign o_fb_literals    = r_lits;
    assign o_fb_state_in    = r_state_op;
    assign o_fb_weight_in   = r_weight_op;

endmodule

// File: tb/tb_feedback_scheduler.sv
// Bench for feedback_scheduler: clause memory and a simple feedback datapath
// as environment, with a per-cycle expected schedule built from a pass list.
module tb_feedback_scheduler;

    localparam int CN  = 4;
    localparam int LN  = 8;
    localparam int STW = 4;
    localparam int WW  = 8;
    localparam int AW  = 2;
    localparam int SW  = LN * STW;
    localparam int MW  = WW + SW;

    logic          clk = 1'b0;
    logic          rst, start, pos;
    logic [LN-1:0] lits;
    logic [CN-1:0] conj, mask;
    logic          busy, done, rd_en, wr_en, fb_en, fb_pos, fb_match;
    logic [AW-1:0] addr;
    logic [MW-1:0] rd_data, wr_data;
    logic [LN-1:0] fb_actions, fb_literals;
    logic [SW-1:0] fb_state_in, fb_state_out;
    logic [WW-1:0] fb_weight_in, fb_weight_out;

    logic [MW-1:0] env_mem [CN];
    logic          tb_we;
    logic [AW-1:0] tb_wa;
    logic [MW-1:0] tb_wd;

    logic [MW-1:0] mdl_mem [CN];
    logic          m_pos;
    logic [LN-1:0] m_lits;
    logic [CN-1:0] m_conj, m_mask;

    int checks   = 0;
    int failures = 0;
    int bcnt, dcyc;

    always #5 clk = ~clk;

    feedback_scheduler dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_is_positive_sample(pos), .i_literals(lits),
        .i_conjunction_result(conj), .i_clause_mask(mask),
        .o_busy(busy), .o_done(done),
        .o_mem_rd_en(rd_en), .o_mem_wr_en(wr_en), .o_mem_addr(addr),
        .i_mem_rd_data(rd_data), .o_mem_wr_data(wr_data),
        .o_fb_en(fb_en), .o_fb_is_positive(fb_pos), .o_fb_match(fb_match),
        .o_fb_actions(fb_actions), .o_fb_literals(fb_literals),
        .o_fb_state_in(fb_state_in), .o_fb_weight_in(fb_weight_in),
        .i_fb_state_out(fb_state_out), .i_fb_weight_out(fb_weight_out)
    );

    // Feedback datapath stand-in: literal 0 decrements its automaton (floor 0),
    // a matching clause moves its weight toward the sample polarity.
    function automatic logic [SW-1:0] dp_state(input logic [SW-1:0] s, input logic [LN-1:0] l);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < LN; i++)
            if (!l[i] && s[i*STW +: STW] != '0) r[i*STW +: STW] = s[i*STW +: STW] - 4'd1;
        return r;
    endfunction

    function automatic logic [WW-1:0] dp_weight(input logic [WW-1:0] w, input logic m, input logic p);
        if (!m) return w;
        return p ? w + 8'd1 : w - 8'd1;
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= env_mem[addr];
        if (wr_en) env_mem[addr] <= wr_data;
        else if (tb_we) env_mem[tb_wa] <= tb_wd;
        if (fb_en) begin
            fb_state_out  <= dp_state(fb_state_in, fb_literals);
            fb_weight_out <= dp_weight(fb_weight_in, fb_match, fb_pos);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit rnd, input logic [MW-1:0] d);
        for (int c = 0; c < CN; c++) begin
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            @(negedge clk);
            tb_we = 1'b1;
            tb_wa = AW'(c);
            tb_wd = rnd ? r[MW-1:0] : d;
            mdl_mem[c] = tb_wd;
        end
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic rand_inputs();
        pos  = 1'($urandom());
        lits = LN'($urandom());
        conj = CN'($urandom());
        mask = CN'($urandom());
    endtask

    task automatic check_all_zero();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_rd_en", 64'(rd_en), 0);
        chk("rst_wr_en", 64'(wr_en), 0);
        chk("rst_fb_en", 64'(fb_en), 0);
        chk("rst_addr", 64'(addr), 0);
        chk("rst_wr_data", 64'(wr_data), 0);
        chk("rst_fb_pos", 64'(fb_pos), 0);
        chk("rst_fb_match", 64'(fb_match), 0);
        chk("rst_fb_actions", 64'(fb_actions), 0);
        chk("rst_fb_literals", 64'(fb_literals), 0);
        chk("rst_fb_state_in", 64'(fb_state_in), 0);
        chk("rst_fb_weight_in", 64'(fb_weight_in), 0);
    endtask

    task automatic check_mem();
        for (int c = 0; c < CN; c++) chk($sformatf("mem_word%0d", c), 64'(env_mem[c]), 64'(mdl_mem[c]));
    endtask

    // Called at a negedge with start=1 and inputs set while the DUT is idle.
    // kind: 0 skip, 1 read, 2 load, 3 apply, 4 write.
    task automatic run_pass(input bit noise, input bit chain, input int abort_at,
                            output int busy_cnt, output int done_cyc);
        int kind[$];
        int cc[$];
        m_pos = pos; m_lits = lits; m_conj = conj; m_mask = mask;
        for (int c = 0; c < CN; c++) begin
            if (m_mask[c]) begin
                for (int j = 1; j <= 4; j++) begin kind.push_back(j); cc.push_back(c); end
            end else begin
                kind.push_back(0); cc.push_back(c);
            end
        end
        busy_cnt = 0;
        done_cyc = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < kind.size(); k++) begin
            int c;
            c = cc[k];
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1 && done_cyc == 0) done_cyc = k + 1;
            chk("busy_high", 64'(busy), 1);
            chk("done_low", 64'(done), 0);
            chk("rd_en", 64'(rd_en), 64'(kind[k] == 1));
            chk("wr_en", 64'(wr_en), 64'(kind[k] == 4));
            chk("fb_en", 64'(fb_en), 64'(kind[k] == 3));
            chk("rd_wr_excl", 64'(rd_en & wr_en), 0);
            if (kind[k] == 1 || kind[k] == 4) chk("mem_addr", 64'(addr), 64'(c));
            if (kind[k] == 3 || kind[k] == 4) begin
                logic [LN-1:0] act;
                for (int i = 0; i < LN; i++) act[i] = mdl_mem[c][i*STW + STW - 1];
                chk("fb_state_in", 64'(fb_state_in), 64'(mdl_mem[c][SW-1:0]));
                chk("fb_weight_in", 64'(fb_weight_in), 64'(mdl_mem[c][MW-1:SW]));
                chk("fb_match", 64'(fb_match), 64'(m_conj[c]));
                chk("fb_is_positive", 64'(fb_pos), 64'(m_pos));
                chk("fb_literals", 64'(fb_literals), 64'(m_lits));
                chk("fb_actions", 64'(fb_actions), 64'(act));
            end
            if (kind[k] == 4) begin
                logic [MW-1:0] nw;
                nw = {dp_weight(mdl_mem[c][MW-1:SW], m_conj[c], m_pos), dp_state(mdl_mem[c][SW-1:0], m_lits)};
                chk("mem_wr_data", 64'(wr_data), 64'(nw));
                mdl_mem[c] = nw;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                check_all_zero();
                return;
            end
            if (noise) begin
                start = 1'($urandom());
                rand_inputs();
            end
            @(negedge clk);
        end
        if (done === 1'b1 && done_cyc == 0) done_cyc = kind.size() + 1;
        chk("done_pulse", 64'(done), 1);
        chk("busy_low", 64'(busy), 0);
        if (chain) begin
            rand_inputs();
            start = 1'b1;
        end else begin
            start = 1'b0;
            @(negedge clk);
            chk("done_once", 64'(done), 0);
            chk("stay_idle", 64'(busy), 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pos = 1'b0; lits = '0; conj = '0; mask = '0;
        tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        repeat (3) @(negedge clk);
        check_all_zero();
        rst = 1'b0;

        // start together with reset is ignored
        @(negedge clk);
        rst = 1'b1; start = 1'b1; mask = 4'hF;
        @(negedge clk);
        chk("start_with_rst", 64'(busy), 0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_with_rst_after", 64'(busy | rd_en), 0);

        // directed full pass
        preload(1'b0, {8'h00, 32'h33333333});
        pos = 1'b1; lits = 8'b11001100; conj = 4'b1010; mask = 4'b1111; start = 1'b1;
        run_pass(1'b0, 1'b0, -1, bcnt, dcyc);
        chk("full_busy_cycles", 64'(bcnt), 16);
        chk("full_done_cycle", 64'(dcyc), 17);
        chk("full_word0", 64'(env_mem[0]), 64'({8'd0, 32'h33223322}));
        chk("full_word1", 64'(env_mem[1]), 64'({8'd1, 32'h33223322}));
        chk("full_word2", 64'(env_mem[2]), 64'({8'd0, 32'h33223322}));
        chk("full_word3", 64'(env_mem[3]), 64'({8'd1, 32'h33223322}));

        // all clauses masked out
        rand_inputs(); mask = 4'b0000; start = 1'b1;
        run_pass(1'b0, 1'b0, -1, bcnt, dcyc);
        chk("empty_busy_cycles", 64'(bcnt), 4);
        chk("empty_done_cycle", 64'(dcyc), 5);
        check_mem();

        // single clause
        preload(1'b1, '0);
        rand_inputs(); mask = 4'b0100; start = 1'b1;
        run_pass(1'b0, 1'b0, -1, bcnt, dcyc);
        chk("single_busy_cycles", 64'(bcnt), 7);
        chk("single_done_cycle", 64'(dcyc), 8);
        check_mem();

        // start pulses and input churn during the pass
        rand_inputs(); mask = 4'b1111; start = 1'b1;
        run_pass(1'b1, 1'b0, -1, bcnt, dcyc);
        chk("noise_done_cycle", 64'(dcyc), 17);
        check_mem();

        // reset in APPLY of clause 1, then a clean pass
        preload(1'b1, '0);
        rand_inputs(); mask = 4'b1111; start = 1'b1;
        run_pass(1'b0, 1'b0, 6, bcnt, dcyc);
        check_mem();
        @(negedge clk);
        rand_inputs(); start = 1'b1;
        run_pass(1'b0, 1'b0, -1, bcnt, dcyc);
        check_mem();

        // back-to-back: start on the done cycle
        rand_inputs(); start = 1'b1;
        run_pass(1'b0, 1'b1, -1, bcnt, dcyc);
        run_pass(1'b0, 1'b0, -1, bcnt, dcyc);
        check_mem();

        // randomized passes
        for (int n = 0; n < 10; n++) begin
            if (n % 3 == 0) preload(1'b1, '0);
            rand_inputs(); start = 1'b1;
            run_pass(1'($urandom()), 1'b0, -1, bcnt, dcyc);
            check_mem();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
